// File: rtl/nes_pad_responder.sv
// Controller end of the NES joypad link: debounced buttons feeding a 4021-style shift register.
// Optional A/B turbo is compiled in when PAD_TURBO_EN is defined.
module nes_pad_responder #(
    parameter int DEBOUNCE_DIV = 16000,
    parameter int DEBOUNCE_N   = 4,
    parameter int TURBO_DIV    = 533333
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] btn_n,
    input  logic       joy_strobe,
    input  logic       joy_clock,
`ifdef PAD_TURBO_EN
    input  logic [1:0] turbo_n,
`endif
    output logic       joy_data,
    output logic [7:0] pressed,
    output logic [3:0] read_count
);
    localparam int DW = (DEBOUNCE_DIV > 1) ? $clog2(DEBOUNCE_DIV) : 1;

    logic [7:0] btn_meta, btn_sync;
    logic       strobe_meta, strobe_sync;
    logic       clk_meta, clk_sync, clk_prev;
    logic       clk_rise;

    always_ff @(posedge clock) begin
        if (reset) begin
            btn_meta    <= '0;
            btn_sync    <= '0;
            strobe_meta <= 1'b0;
            strobe_sync <= 1'b0;
            clk_meta    <= 1'b0;
            clk_sync    <= 1'b0;
            clk_prev    <= 1'b0;
        end else begin
            btn_meta    <= btn_n;
            btn_sync    <= btn_meta;
            strobe_meta <= joy_strobe;
            strobe_sync <= strobe_meta;
            clk_meta    <= joy_clock;
            clk_sync    <= clk_meta;
            clk_prev    <= clk_sync;
        end
    end

    assign clk_rise = clk_sync & ~clk_prev;

    // Debounce sample tick, one cycle wide at prescaler wrap.
    logic [DW-1:0] pre;
    logic          tick;
    assign tick = (pre == DW'(DEBOUNCE_DIV - 1));

    always_ff @(posedge clock) begin
        if (reset)     pre <= '0;
        else if (tick) pre <= '0;
        else           pre <= pre + 1'b1;
    end

    logic [3:0] agree [8];
    logic [7:0] sample;
    assign sample = ~btn_sync;

    always_ff @(posedge clock) begin
        if (reset) begin
            pressed <= '0;
            for (int i = 0; i < 8; i++) agree[i] <= '0;
        end else if (tick) begin
            for (int i = 0; i < 8; i++) begin
                if (sample[i] == pressed[i]) begin
                    agree[i] <= '0;
                end else if (agree[i] == 4'(DEBOUNCE_N - 1)) begin
                    pressed[i] <= sample[i];
                    agree[i]   <= '0;
                end else begin
                    agree[i] <= agree[i] + 4'd1;
                end
            end
        end
    end

    logic [7:0] eff_pressed;

`ifdef PAD_TURBO_EN
    localparam int TW = (TURBO_DIV > 1) ? $clog2(TURBO_DIV) : 1;

    logic [1:0]    turbo_meta, turbo_sync;
    logic [TW-1:0] turbo_cnt;
    logic          turbo_phase;

    always_ff @(posedge clock) begin
        if (reset) begin
            turbo_meta  <= '0;
            turbo_sync  <= '0;
            turbo_cnt   <= '0;
            turbo_phase <= 1'b0;
        end else begin
            turbo_meta <= turbo_n;
            turbo_sync <= turbo_meta;
            if (turbo_cnt == TW'(TURBO_DIV - 1)) begin
                turbo_cnt   <= '0;
                turbo_phase <= ~turbo_phase;
            end else begin
                turbo_cnt <= turbo_cnt + 1'b1;
            end
        end
    end

    // A held turbo button only reads as pressed during phase 1.
    assign eff_pressed = {pressed[7:2], pressed[1:0] & (turbo_sync | {2{turbo_phase}})};
`else
    assign eff_pressed = pressed;
`endif

    // Load dominates shifting; the fill bit of 1 makes reads past eight return "pressed".
    logic [7:0] sr;

    always_ff @(posedge clock) begin
        if (reset) begin
            sr         <= '0;
            read_count <= '0;
            joy_data   <= 1'b1;
        end else begin
            if (strobe_sync) begin
                sr         <= eff_pressed;
                read_count <= '0;
            end else if (clk_rise) begin
                sr <= {1'b1, sr[7:1]};
                if (read_count != 4'd8) read_count <= read_count + 4'd1;
            end
            joy_data <= ~sr[0];
        end
    end
endmodule

// File: tb/tb_nes_pad_responder.sv
// Scoreboard bench for nes_pad_responder: drivers push expectations, a negedge monitor pops and compares.
// Turbo checks run only when PAD_TURBO_EN is defined.
module tb_nes_pad_responder;
    localparam int DB_DIV = 4;
    localparam int DB_N   = 4;
    localparam int T_DIV  = 8;
    localparam int SETTLE = 40;

    localparam logic [3:0] K_DATA  = 4'd1;
    localparam logic [3:0] K_PRESS = 4'd2;
    localparam logic [3:0] K_COUNT = 4'd3;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] btn_n;
    logic       joy_strobe;
    logic       joy_clock;
    logic [1:0] turbo_n;
    logic       joy_data;
    logic [7:0] pressed;
    logic [3:0] read_count;

    nes_pad_responder #(
        .DEBOUNCE_DIV(DB_DIV),
        .DEBOUNCE_N  (DB_N),
        .TURBO_DIV   (T_DIV)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .btn_n      (btn_n),
        .joy_strobe (joy_strobe),
        .joy_clock  (joy_clock),
`ifdef PAD_TURBO_EN
        .turbo_n    (turbo_n),
`endif
        .joy_data   (joy_data),
        .pressed    (pressed),
        .read_count (read_count)
    );

    // clock / reset-relative cycle counter
    always #5 clock = ~clock;

    int cyc;
    always @(posedge clock) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // scoreboard: entry = {kind[3:0], value[7:0]}
    logic [11:0] exp_q[$];
    logic        sample_req = 1'b0;
    int          n_vec  = 0;
    int          n_fail = 0;
    logic [11:0] e;
    logic [7:0]  act;

    function automatic string kind_name(input logic [3:0] k);
        case (k)
            K_DATA:  return "joy_data";
            K_PRESS: return "pressed";
            default: return "read_count";
        endcase
    endfunction

    always @(negedge clock) begin
        if (sample_req) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_underflow: observation with no expectation at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                case (e[11:8])
                    K_DATA:  act = {7'd0, joy_data};
                    K_PRESS: act = pressed;
                    default: act = {4'd0, read_count};
                endcase
                if (act !== e[7:0]) begin
                    n_fail++;
                    $display("FAIL %s: got %0h expected %0h at %0t", kind_name(e[11:8]), act, e[7:0], $time);
                end
            end
        end
    end

    // driver tasks
    task automatic cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic expect_obs(input logic [3:0] kind, input logic [7:0] val);
        exp_q.push_back({kind, val});
        sample_req = 1'b1;
        @(negedge clock);
        #1;
        sample_req = 1'b0;
    endtask

    task automatic set_btn(input logic [7:0] b);
        btn_n = b;
        cycles(SETTLE);
    endtask

    task automatic strobe_pulse();
        joy_strobe = 1'b1;
        cycles(4);
        joy_strobe = 1'b0;
        cycles(4);
    endtask

    task automatic clock_pulse();
        joy_clock = 1'b1;
        cycles($urandom_range(3, 5));
        joy_clock = 1'b0;
        cycles($urandom_range(3, 5));
    endtask

    // Reference: read k shows ~p[k] for the first eight reads, then 0; count saturates at 8.
    task automatic read_all(input logic [7:0] p, input int nreads);
        strobe_pulse();
        for (int k = 0; k < nreads; k++) begin
            expect_obs(K_DATA, (k < 8) ? {7'd0, ~p[k]} : 8'd0);
            expect_obs(K_COUNT, (k < 8) ? 8'(k) : 8'd8);
            clock_pulse();
        end
    endtask

    initial begin
        logic [7:0] b;
        reset      = 1'b1;
        btn_n      = 8'hFF;
        joy_strobe = 1'b0;
        joy_clock  = 1'b0;
        turbo_n    = 2'b11;
        cycles(3);
        expect_obs(K_DATA, 8'd1);
        expect_obs(K_COUNT, 8'd0);
        expect_obs(K_PRESS, 8'h00);
        reset = 1'b0;
        cycles(2);

        // A held: A bit first, then released bits, then fill reads as pressed
        set_btn(8'hFE);
        expect_obs(K_PRESS, 8'h01);
        read_all(8'h01, 10);

        set_btn(8'h6F);
        expect_obs(K_PRESS, ~8'h6F);
        read_all(~8'h6F, 8);

        // glitch of DEBOUNCE_N-2 ticks must not register
        set_btn(8'hFF);
        expect_obs(K_PRESS, 8'h00);
        btn_n = 8'hFE;
        cycles((DB_N - 2) * DB_DIV);
        btn_n = 8'hFF;
        cycles(SETTLE);
        expect_obs(K_PRESS, 8'h00);
        read_all(8'h00, 9);

        // strobe held: clocks ignored, data follows A
        set_btn(8'hFE);
        joy_strobe = 1'b1;
        cycles(4);
        for (int i = 0; i < 3; i++) begin
            clock_pulse();
            expect_obs(K_DATA, 8'd0);
            expect_obs(K_COUNT, 8'd0);
        end
        set_btn(8'hFF);
        expect_obs(K_DATA, 8'd1);
        set_btn(8'hFE);
        expect_obs(K_DATA, 8'd0);
        expect_obs(K_COUNT, 8'd0);
        joy_strobe = 1'b0;
        cycles(4);
        expect_obs(K_DATA, 8'd0);
        expect_obs(K_COUNT, 8'd0);

        // reset mid-sequence
        b = 8'(~8'h05);
        set_btn(b);
        strobe_pulse();
        for (int i = 0; i < 4; i++) clock_pulse();
        expect_obs(K_COUNT, 8'd4);
        reset = 1'b1;
        cycles(1);
        expect_obs(K_DATA, 8'd1);
        expect_obs(K_COUNT, 8'd0);
        expect_obs(K_PRESS, 8'h00);
        reset = 1'b0;
        cycles(SETTLE);
        expect_obs(K_PRESS, ~b);
        read_all(~b, 9);

        // randomized patterns
        for (int r = 0; r < 6; r++) begin
            b = 8'($urandom_range(0, 255));
            set_btn(b);
            expect_obs(K_PRESS, ~b);
            read_all(~b, $urandom_range(1, 10));
        end

`ifdef PAD_TURBO_EN
        // A and B held, turbo on A only; phase after edge k is (k / T_DIV) % 2
        btn_n   = 8'hFC;
        turbo_n = 2'b10;
        reset   = 1'b1;
        cycles(2);
        reset = 1'b0;
        cycles(SETTLE);
        joy_strobe = 1'b1;
        cycles(8);
        for (int w = 0; w < 4; w++) begin
            for (int t = 0; t < T_DIV && (cyc % T_DIV) != T_DIV / 2; t++) cycles(1);
            expect_obs(K_DATA, (((cyc / T_DIV) % 2) == 1) ? 8'd0 : 8'd1);
            cycles(1);
        end
        cycles(T_DIV / 2);
        joy_strobe = 1'b0;
        cycles(4);
        clock_pulse();
        expect_obs(K_DATA, 8'd0);
        turbo_n = 2'b11;
`endif

        cycles(2);
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_leftover: %0d entries pending, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
